// File: rtl/bd_if_pkg.sv
// Shared definitions for the FPGA<->BD pin-side datapath: pin word widths
// and the input arbiter state encoding.
package bd_if_pkg;

    localparam int NUM_BITS_PIN2CORE = 21;
    localparam int NUM_BITS_CORE2PIN = 34;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

endpackage

// File: rtl/bd_input_arbiter_if.sv
// Source-side and output-side word streams of the input arbiter; the slave
// modport is the arbiter's view, the master modport the surrounding logic's.
interface bd_input_arbiter_if
    import bd_if_pkg::*;
#(
    parameter int NUM_SRC  = 4,
    parameter int NUM_BITS = NUM_BITS_PIN2CORE
);

    logic [NUM_SRC-1:0]               src_v;
    logic [NUM_SRC-1:0][NUM_BITS-1:0] src_d;
    logic [NUM_SRC-1:0]               src_a;
    logic                             out_v;
    logic [NUM_BITS-1:0]              out_d;
    logic                             out_a;

    modport master (
        output src_v, src_d, out_a,
        input  src_a, out_v, out_d
    );

    modport slave (
        input  src_v, src_d, out_a,
        output src_a, out_v, out_d
    );

endinterface

// File: rtl/bd_skid_fifo2.sv
// Two-entry FIFO whose output valid and data come straight from registers;
// head is always the word presented downstream, tail the one behind it.
module bd_skid_fifo2
    import bd_if_pkg::*;
#(
    parameter int NUM_BITS = NUM_BITS_PIN2CORE
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_v,
    input  logic [NUM_BITS-1:0] in_d,
    output logic                in_a,
    output logic                out_v,
    output logic [NUM_BITS-1:0] out_d,
    input  logic                out_a,
    output logic                full,
    output logic [1:0]          count
);

    logic [1:0]          cnt;
    logic [NUM_BITS-1:0] head;
    logic [NUM_BITS-1:0] tail;
    logic                push;
    logic                pop;

    // Space is judged on the current count only, so a full FIFO refuses a
    // push even on an edge where it is also popped.
    assign in_a  = (cnt != 2'd2);
    assign push  = in_v & in_a;
    assign pop   = out_v & out_a;
    assign out_v = (cnt != 2'd0);
    assign out_d = head;
    assign full  = ~in_a;
    assign count = cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= 2'd0;
        end else begin
            unique case ({push, pop})
                2'b10:   cnt <= cnt + 2'd1;
                2'b01:   cnt <= cnt - 2'd1;
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push && (cnt == 2'd0 || (cnt == 2'd1 && pop))) begin
            head <= in_d;
        end else if (push) begin
            tail <= in_d;
        end else if (pop && cnt == 2'd2) begin
            head <= tail;
        end
    end

endmodule

// File: rtl/bd_input_arbiter.sv
// Round-robin merge of NUM_SRC word streams into one registered stream with
// bounded bursts; BD_INPUT_ARBITER_STATS_EN adds per-source word counters.
module bd_input_arbiter
    import bd_if_pkg::*;
#(
    parameter int NUM_SRC   = 4,
    parameter int NUM_BITS  = NUM_BITS_PIN2CORE,
    parameter int MAX_BURST = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    bd_input_arbiter_if.slave          bus
`ifdef BD_INPUT_ARBITER_STATS_EN
    ,
    input  logic [$clog2(NUM_SRC)-1:0] stat_sel,
    input  logic                       stat_clr,
    output logic [31:0]                stat_cnt
`endif
);

    localparam int IDX_W = $clog2(NUM_SRC);

    arb_state_t          state;
    logic [IDX_W-1:0]    grant;
    logic [IDX_W-1:0]    last_grant;
    logic [7:0]          burst_cnt;
    logic                req_v;
    logic [NUM_BITS-1:0] req_d;
    logic                fifo_in_a;
    logic                fifo_full_unused;
    logic [1:0]          fifo_count;
    logic                take;
    logic [IDX_W-1:0]    next_grant;

    // Nearest requester after 'last', wrapping; later hits are overwritten by
    // nearer ones because the loop walks from farthest to nearest.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_SRC-1:0] v,
                                                  input logic [IDX_W-1:0]   last);
        logic [IDX_W-1:0] idx;
        rr_pick = last;
        for (int i = NUM_SRC; i >= 1; i--) begin
            idx = IDX_W'((int'(last) + i) % NUM_SRC);
            if (v[idx]) rr_pick = idx;
        end
    endfunction

    assign next_grant = rr_pick(bus.src_v, last_grant);
    assign req_v      = (state == GRANT) & bus.src_v[grant];
    assign req_d      = bus.src_d[grant];
    assign take       = req_v & fifo_in_a;

    // Accept is a pure decode of state, grant and FIFO occupancy registers.
    always_comb begin
        bus.src_a = '0;
        if (state == GRANT && fifo_count < 2'd2) bus.src_a[grant] = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            grant      <= '0;
            last_grant <= IDX_W'(NUM_SRC - 1);
            burst_cnt  <= 8'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (|bus.src_v) begin
                        grant      <= next_grant;
                        last_grant <= next_grant;
                        burst_cnt  <= 8'd0;
                        state      <= GRANT;
                    end
                end
                GRANT: begin
                    if (!bus.src_v[grant]) begin
                        state <= IDLE;
                    end else if (take) begin
                        burst_cnt <= burst_cnt + 8'd1;
                        if (burst_cnt == 8'(MAX_BURST - 1)) state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    bd_skid_fifo2 #(.NUM_BITS(NUM_BITS)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .in_v  (req_v),
        .in_d  (req_d),
        .in_a  (fifo_in_a),
        .out_v (bus.out_v),
        .out_d (bus.out_d),
        .out_a (bus.out_a),
        .full  (fifo_full_unused),
        .count (fifo_count)
    );

`ifdef BD_INPUT_ARBITER_STATS_EN
    logic [31:0] stat_q [NUM_SRC];

    // Clear takes priority over a transfer landing on the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_SRC; i++) stat_q[i] <= 32'd0;
        end else if (stat_clr) begin
            for (int i = 0; i < NUM_SRC; i++) stat_q[i] <= 32'd0;
        end else if (take) begin
            stat_q[grant] <= stat_q[grant] + 32'd1;
        end
    end

    assign stat_cnt = stat_q[stat_sel];
`endif

endmodule
